// File: rtl/move_collector.sv
// Move collector: snapshots one square's move registers on request and
// streams every nonzero move word out as a record, lowest slot first,
// under a valid/ready handshake.
module move_collector #(
  parameter bit KNIGHT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  pos_in,
  input  logic [87:0] slide_in,
  input  logic [63:0] knight_in,
  input  logic        m_ready,
  output logic        m_valid,
  output logic [21:0] m_data,
  output logic        busy,
  output logic        done,
  output logic [4:0]  move_count
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

  state_t      state_q;
  logic [15:0] pending_q;
  logic [87:0] slideSnap_q;
  logic [63:0] knightSnap_q;
  logic [5:0]  posSnap_q;
  logic        mValid_q;
  logic [21:0] mData_q;
  logic        busy_q;
  logic        done_q;
  logic [4:0]  moveCount_q;

  logic [15:0] pendingInit_d;
  logic [3:0]  selSlot_d;
  logic [10:0] selPayload_d;
  logic [21:0] selRecord_d;
  logic [15:0] pendingNext_d;

  // One pending bit per nonzero word of the live inputs; knight slots are
  // dropped entirely when knights are disabled.
  always_comb begin
    pendingInit_d = '0;
    for (int k = 0; k < 8; k++) begin
      pendingInit_d[k]     = |slide_in[11*k +: 11];
      pendingInit_d[8 + k] = KNIGHT_EN & (|knight_in[8*k +: 8]);
    end
  end

  // Pick the lowest pending slot, build its record from the snapshot and
  // form the pending mask with that slot retired.
  always_comb begin
    selSlot_d = '0;
    for (int k = 15; k >= 0; k--) begin
      if (pending_q[k]) selSlot_d = 4'(k);
    end
    selPayload_d = '0;
    for (int k = 0; k < 8; k++) begin
      if (selSlot_d == 4'(k))     selPayload_d = slideSnap_q[11*k +: 11];
      if (selSlot_d == 4'(8 + k)) selPayload_d = {3'b000, knightSnap_q[8*k +: 8]};
    end
    selRecord_d   = {selSlot_d, selSlot_d[3], selPayload_d, posSnap_q};
    pendingNext_d = pending_q & ~(16'd1 << selSlot_d);
  end

  // Collection FSM: snapshot on start, scan for the first record, hand
  // records off one per accepted cycle, then pulse done and return to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      slideSnap_q  <= '0;
      knightSnap_q <= '0;
      posSnap_q    <= '0;
      mValid_q     <= 1'b0;
      mData_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      moveCount_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            slideSnap_q  <= slide_in;
            knightSnap_q <= knight_in;
            posSnap_q    <= pos_in;
            pending_q    <= pendingInit_d;
            moveCount_q  <= '0;
            busy_q       <= 1'b1;
            state_q      <= SCAN;
          end
        end
        SCAN: begin
          if (pending_q == '0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            mData_q   <= selRecord_d;
            mValid_q  <= 1'b1;
            pending_q <= pendingNext_d;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (m_ready) begin
            moveCount_q <= moveCount_q + 5'd1;
            if (pending_q != '0) begin
              mData_q   <= selRecord_d;
              pending_q <= pendingNext_d;
            end else begin
              mValid_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_valid    = mValid_q;
  assign m_data     = mData_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign move_count = moveCount_q;

endmodule

// File: doc/move_collector.md
MOVE_COLLECTOR -- requirements
Module: move_collector

Interface
REQ-001 Parameter KNIGHT_EN, default 1: when 1, knight slots 8-15 are collected; when 0, they are masked out of the snapshot.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  single-cycle request to begin one collection pass.
REQ-005 pos_in  input  6  board index of the square whose move registers are collected.
REQ-006 slide_in  input  88  eight 11-bit sliding/king/pawn move words; slot k occupies bits [11k+10:11k]; order U, D, L, R, UL, UR, DL, DR (slots 0-7).
REQ-007 knight_in  input  64  eight 8-bit knight move words; slot 8+j occupies bits [8j+7:8j]; order UUL, UUR, LLU, RRU, DDL, DDR, LLD, RRD (slots 8-15).
REQ-008 m_ready  input  1  downstream accepts m_data this cycle.
REQ-009 m_valid  output  1  m_data holds a collected move.
REQ-010 m_data  output  22  collected move record {slot[3:0], is_knight, payload[10:0], pos[5:0]}.
REQ-011 busy  output  1  high from the cycle after an accepted start until done.
REQ-012 done  output  1  one-cycle pulse at the end of a pass.
REQ-013 move_count  output  5  number of records accepted in the current or last pass (0-16).

Function
REQ-014 FSM states: IDLE, SCAN, HOLD, DONE.
REQ-015 In IDLE, start=1: snapshot slide_in, knight_in and pos_in; build pending[15:0] with bit k = 1 iff slot k's word is nonzero (bits 8-15 forced to 0 when KNIGHT_EN=0); clear move_count; go to SCAN.
REQ-016 start is ignored outside IDLE; input changes after the snapshot do not affect the pass.
REQ-017 In SCAN: if pending is zero, go to DONE; otherwise select the lowest-index set bit, load m_data, assert m_valid, clear that pending bit, and go to HOLD.
REQ-018 Field formation: slot = selected index; is_knight = (slot >= 8); payload = the 11-bit word, or the 8-bit knight word zero-extended to 11 bits; pos = snapshot pos.
REQ-019 In HOLD, while m_valid=1 and m_ready=0: m_data and m_valid hold stable.
REQ-020 In HOLD, on m_ready=1: move_count increments. If pending is nonzero, the next record loads in the same cycle and m_valid stays high, giving one record per cycle under continuous ready. If pending is zero, m_valid drops and the FSM goes to DONE.
REQ-021 In DONE: done=1 for exactly one cycle, then IDLE; move_count holds until the next accepted start.
REQ-022 Latency: first m_valid occurs 2 cycles after start (one cycle to snapshot, one in SCAN); done occurs 2 cycles after start for an all-zero snapshot.
REQ-023 busy = 1 in SCAN, HOLD and DONE; busy = 0 in IDLE.
REQ-024 A word equal to zero is never emitted; any nonzero word is emitted regardless of its direction flag bits (bit 9 manhattan, bit 8 diagonal).
REQ-025 move_count saturates naturally at 16; it does not wrap within a pass.

Reset
REQ-026 rst=1 takes priority over all other inputs in the same cycle, including start and m_ready.
REQ-027 Reset values: state IDLE, pending 0, m_valid 0, m_data 0, busy 0, done 0, move_count 0.
REQ-028 rst asserted mid-pass abandons the pass: no further records are emitted and done does not pulse.

Verification
REQ-029 All-zero inputs, start -> no m_valid; done pulses 2 cycles after start; move_count = 0.
REQ-030 pos_in=6'd27, U=11'h201, DR=11'h105, UUL=8'h3C, m_ready held 1 -> three consecutive records with slot 0, 7, 8; record 3 = {4'd8, 1, 11'h03C, 6'd27}; move_count = 3.
REQ-031 All 16 slots nonzero, m_ready=1 -> 16 back-to-back records in slot order 0-15; done follows; move_count = 16.
REQ-032 Two slots valid, m_ready held 0 for 5 cycles then 1 -> first record stable all 5 cycles; no duplicate or lost record.
REQ-033 KNIGHT_EN=0 with only knight inputs nonzero -> no records emitted; done pulses; move_count = 0.
REQ-034 start again while busy, then rst in HOLD -> second start ignored; after rst, m_valid = 0 and state IDLE; no done pulse.
